// File: rtl/block_ram_req_ctrl_pkg.sv
// Shared definitions for the BlockRAM request front-end.
// Write acknowledgements are compiled in only when BRAM_CTRL_WACK_EN is defined (default: off).
package block_ram_req_ctrl_pkg;

    localparam int unsigned RspDepthDefault = 4;

    typedef enum logic {
        RspRead  = 1'b0,
        RspWrite = 1'b1
    } rsp_kind_e;

    // Counter must hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/block_ram_rsp_fifo.sv
// In-order response FIFO: push/pop, occupancy count and head data.
// Used by block_ram_req_ctrl (BRAM_CTRL_WACK_EN only changes the entry width).
module block_ram_rsp_fifo
    import block_ram_req_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = RspDepthDefault
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            push_data_i,
    input  logic                        pop_i,
    output logic [cnt_width(DEPTH)-1:0] count_o,
    output logic                        valid_o,
    output logic [WIDTH-1:0]            head_data_o
);

    localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CntW    = cnt_width(DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_pop;

    always_comb begin
        do_pop   = pop_i & (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_i && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o     = count_q;
    assign valid_o     = (count_q != '0);
    assign head_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/block_ram_req_ctrl.sv
// Valid/ready front-end for a single-port BlockRAM with credit-limited in-order responses.
// Define BRAM_CTRL_WACK_EN to return a response (RSP_IS_WRITE=1, data 0) for every write.
module block_ram_req_ctrl
    import block_ram_req_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned RSP_DEPTH  = RspDepthDefault
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
`ifdef BRAM_CTRL_WACK_EN
    output logic                  RSP_IS_WRITE,
`endif
    output logic [DATA_WIDTH-1:0] RAM_DI,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic                  RAM_WE,
    output logic                  RAM_RE,
    input  logic [DATA_WIDTH-1:0] RAM_DO
);

    localparam int unsigned CntW = cnt_width(RSP_DEPTH);
`ifdef BRAM_CTRL_WACK_EN
    localparam int unsigned EntryW = DATA_WIDTH + 1;
`else
    localparam int unsigned EntryW = DATA_WIDTH;
`endif

    logic [CntW-1:0]   count;
    logic [CntW:0]     credits_used;
    logic              fire;
    logic              rsp_fire;
    logic              pop;
    logic              inflight_q, inflight_d;
    logic [EntryW-1:0] push_data;
    logic [EntryW-1:0] head_data;
`ifdef BRAM_CTRL_WACK_EN
    rsp_kind_e         kind_q, kind_d;
`endif

    // Ready depends only on registered state, so no combinational path from the ports.
    always_comb begin
        credits_used = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
        REQ_READY    = RESET_N & (credits_used < (CntW + 1)'(RSP_DEPTH));
        fire         = REQ_VALID & REQ_READY;
        RAM_ADDR     = REQ_ADDR;
        RAM_DI       = REQ_DATA;
        RAM_WE       = fire & REQ_WE;
        RAM_RE       = fire & ~REQ_WE;
        pop          = RSP_VALID & RSP_READY;
`ifdef BRAM_CTRL_WACK_EN
        rsp_fire     = fire;
        kind_d       = REQ_WE ? RspWrite : RspRead;
        push_data    = {RspRead, RAM_DO};
        if (kind_q == RspWrite) begin
            push_data = {RspWrite, {DATA_WIDTH{1'b0}}};
        end
`else
        rsp_fire     = RAM_RE;
        push_data    = RAM_DO;
`endif
        inflight_d   = rsp_fire;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            inflight_q <= 1'b0;
`ifdef BRAM_CTRL_WACK_EN
            kind_q     <= RspRead;
`endif
        end else begin
            inflight_q <= inflight_d;
`ifdef BRAM_CTRL_WACK_EN
            kind_q     <= kind_d;
`endif
        end
    end

    // RAM_DO is valid exactly one cycle after a response-producing fire.
    block_ram_rsp_fifo #(
        .WIDTH (EntryW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (CLK),
        .rst_ni      (RESET_N),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .count_o     (count),
        .valid_o     (RSP_VALID),
        .head_data_o (head_data)
    );

    assign RSP_DATA = head_data[DATA_WIDTH-1:0];
`ifdef BRAM_CTRL_WACK_EN
    assign RSP_IS_WRITE = head_data[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_block_ram_req_ctrl.sv
// Randomised bench for block_ram_req_ctrl with a behavioural BlockRAM and a queue reference model.
// Build with BRAM_CTRL_WACK_EN defined to also exercise write acknowledgements.
module tb_block_ram_req_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
`ifdef BRAM_CTRL_WACK_EN
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_ready, rsp_valid, ram_we, ram_re;
    logic [DW-1:0] rsp_data, ram_di, ram_do;
    logic [AW-1:0] ram_addr;
`ifdef BRAM_CTRL_WACK_EN
    logic          rsp_is_write;
`endif

    always #5 clk = ~clk;

    block_ram_req_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .CLK          (clk),
        .RESET_N      (rst_n),
        .REQ_VALID    (req_valid),
        .REQ_READY    (req_ready),
        .REQ_WE       (req_we),
        .REQ_ADDR     (req_addr),
        .REQ_DATA     (req_data),
        .RSP_VALID    (rsp_valid),
        .RSP_READY    (rsp_ready),
        .RSP_DATA     (rsp_data),
`ifdef BRAM_CTRL_WACK_EN
        .RSP_IS_WRITE (rsp_is_write),
`endif
        .RAM_DI       (ram_di),
        .RAM_ADDR     (ram_addr),
        .RAM_WE       (ram_we),
        .RAM_RE       (ram_re),
        .RAM_DO       (ram_do)
    );

    // Single-port BlockRAM: synchronous read, DO undefined if WE and RE collide.
    logic [DW-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_we && ram_re) ram_do <= 'x;
        else if (ram_we) ram_mem[ram_addr] <= ram_di;
        else if (ram_re) ram_do <= ram_mem[ram_addr];
    end

    // Reference model: queue of outstanding responses, each visible from a given cycle.
    typedef struct {
        logic [DW-1:0] data;
        logic          is_wr;
        int            avail;
    } rsp_t;
    rsp_t          mq[$];
    logic [DW-1:0] shadow [16];
    int            cyc = 0;
    int            n_vec = 0, n_err = 0;

    logic          obs_ready, obs_rvalid, obs_fire, obs_pop;
    logic [DW-1:0] obs_rdata;
    logic [11:0]   obs_vec, exp_vec;
    logic [1+1+AW+DW-1:0] obs_ram;

    // Applies one cycle of stimulus, snapshots the DUT and advances the model.
    task automatic drive_cycle(input logic v, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic rr);
        rsp_t          e;
        logic          exp_ready, exp_rvalid, exp_wr, obs_wr;
        logic [DW-1:0] exp_rdata, obs_d;
        req_valid = v; req_we = we; req_addr = a; req_data = d; rsp_ready = rr;
        #2;
        exp_ready  = (mq.size() < DEPTH);
        exp_rvalid = (mq.size() != 0) && (mq[0].avail <= cyc);
        exp_rdata  = exp_rvalid ? mq[0].data : '0;
        exp_wr     = exp_rvalid ? mq[0].is_wr : 1'b0;
        obs_ready  = req_ready;
        obs_rvalid = rsp_valid;
        obs_rdata  = rsp_data;
        obs_d      = exp_rvalid ? rsp_data : '0;
`ifdef BRAM_CTRL_WACK_EN
        obs_wr     = exp_rvalid ? rsp_is_write : 1'b0;
`else
        obs_wr     = 1'b0;
`endif
        obs_fire   = v & req_ready;
        obs_pop    = rsp_valid & rr;
        obs_ram    = {ram_we, ram_re, ram_addr, ram_di};
        obs_vec    = {obs_ready, obs_rvalid, ram_we & ram_re, obs_wr, obs_d};
        exp_vec    = {exp_ready, exp_rvalid, 1'b0, exp_wr, exp_rdata};
        if (exp_rvalid && rr) void'(mq.pop_front());
        if (v && exp_ready) begin
            e.avail = cyc + 2;
            if (we) begin
                shadow[a] = d;
                if (WACK) begin
                    e.data = '0; e.is_wr = 1'b1; mq.push_back(e);
                end
            end else begin
                e.data = shadow[a]; e.is_wr = 1'b0; mq.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        req_valid = 1'b1; req_we = 1'b0; rsp_ready = 1'b1;
        #12;
        n_vec++;
        if ({req_ready, rsp_valid, ram_we, ram_re} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold: rdy/vld/we/re got %b want 0000",
                     {req_ready, rsp_valid, ram_we, ram_re});
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_release: rdy/vld got %b want 10", {req_ready, rsp_valid});
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, 1'b1, AW'(i), DW'($urandom), 1'b1);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++; $display("FAIL fill cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_write_read();
        drive_cycle(1'b1, 1'b1, 4'd3, 8'h5A, 1'b1);
        n_vec++;
        if (obs_ram !== {1'b1, 1'b0, 4'd3, 8'h5A}) begin
            n_err++; $display("FAIL wr_drive: ram port got %h want %h", obs_ram,
                              {1'b1, 1'b0, 4'd3, 8'h5A});
        end
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b1);
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b1);
        drive_cycle(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
        n_vec++;
        if (obs_ram[1+1+AW+DW-1 -: 2+AW] !== {1'b0, 1'b1, 4'd3}) begin
            n_err++; $display("FAIL rd_drive: we/re/addr got %h want %h",
                              obs_ram[1+1+AW+DW-1 -: 2+AW], {1'b0, 1'b1, 4'd3});
        end
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b1);
        n_vec++;
        if (obs_rvalid !== 1'b0) begin
            n_err++; $display("FAIL rd_latency1: RSP_VALID got %b want 0", obs_rvalid);
        end
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b1);
        n_vec++;
        if ({obs_rvalid, obs_rdata} !== {1'b1, 8'h5A}) begin
            n_err++; $display("FAIL rd_latency2: vld/data got %b/%h want 1/5a", obs_rvalid,
                              obs_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int pops = 0;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(i < 8, 1'b0, AW'(i), '0, 1'b1);
            if (obs_pop) pops++;
            n_vec++;
            if (obs_vec !== exp_vec || (i < 8 && obs_ready !== 1'b1)) begin
                n_err++; $display("FAIL b2b cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
        end
        n_vec++;
        if (pops !== 8) begin
            n_err++; $display("FAIL b2b_count: responses got %0d want 8", pops);
        end
    endtask

    task automatic test_stall();
        int            acc = 0, pops = 0;
        logic [AW-1:0] na = 4'd8;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b0, na, '0, 1'b0);
            if (obs_fire) begin acc++; na++; end
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++; $display("FAIL stall cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
        end
        n_vec++;
        if (acc !== 4 || obs_ready !== 1'b0) begin
            n_err++; $display("FAIL stall_accept: accepted %0d rdy %b want 4 0", acc, obs_ready);
        end
        for (int i = 0; i < 16; i++) begin
            drive_cycle(acc < 6, 1'b0, na, '0, 1'b1);
            if (obs_fire) begin acc++; na++; end
            if (obs_pop) pops++;
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++; $display("FAIL unstall cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
        end
        n_vec++;
        if (acc !== 6 || pops !== 6) begin
            n_err++; $display("FAIL unstall_count: acc %0d rsp %0d want 6 6", acc, pops);
        end
    endtask

    task automatic test_push_pop();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(i == 0 || i == 2, 1'b0, (i == 0) ? 4'd10 : 4'd5, '0, 1'b1);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++; $display("FAIL pushpop cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            if (i == 2) begin
                n_vec++;
                if ({obs_rvalid, obs_ready, obs_rdata} !== {1'b1, 1'b1, shadow[10]}) begin
                    n_err++; $display("FAIL pushpop_same: vld/rdy/data got %b%b/%h want 11/%h",
                                      obs_rvalid, obs_ready, obs_rdata, shadow[10]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, AW'(i + 1), '0, 1'b0);
        n_vec++;
        if (rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre: RSP_VALID got %b want 1", rsp_valid);
        end
        req_valid = 1'b0;
        rst_n = 1'b0;
        mq.delete();
        #1;
        n_vec++;
        if ({rsp_valid, req_ready} !== 2'b00) begin
            n_err++; $display("FAIL midrst_now: vld/rdy got %b want 00", {rsp_valid, req_ready});
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b0, '0, '0, 1'b1);
            n_vec++;
            if (obs_vec !== exp_vec || obs_ready !== 1'b1) begin
                n_err++; $display("FAIL midrst_post cyc %0d: got %h want %h", cyc, obs_vec,
                                  exp_vec);
            end
        end
    endtask

`ifdef BRAM_CTRL_WACK_EN
    task automatic test_wack();
        logic [DW-1:0] d = DW'($urandom);
        logic [DW:0]   seen [$];
        for (int i = 0; i < 6; i++) begin
            drive_cycle(i < 2, i == 0, 4'd9, d, 1'b1);
            if (obs_pop) seen.push_back({rsp_is_write, obs_rdata});
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++; $display("FAIL wack cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
        end
        n_vec++;
        if (seen.size() != 2 || seen[0] !== {1'b1, 8'h00} || seen[1] !== {1'b0, d}) begin
            n_err++; $display("FAIL wack_order: %0d rsps first %h second %h want 100 0%h",
                              seen.size(), (seen.size() > 0) ? seen[0] : 9'h0,
                              (seen.size() > 1) ? seen[1] : 9'h0, d);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom),
                        DW'($urandom), (i >= 390) || ($urandom_range(0, 3) != 0));
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++; $display("FAIL random cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 1'b0, '0, '0, 1'b1);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++; $display("FAIL drain cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_back_to_back();
        test_stall();
        test_push_pop();
        test_reset_mid();
`ifdef BRAM_CTRL_WACK_EN
        test_wack();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
